// File: rtl/meas_avg_engine.sv
// Multi-channel ADC averaging engine: settle, accumulate 2^AVG_LOG2 samples,
// then hold the averaged result until the consumer takes it.
module meas_avg_engine #(
  parameter int NUM_CH   = 2,
  parameter int ADC_W    = 12,
  parameter int SETTLE_W = 8,
  parameter int AVG_LOG2 = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [SETTLE_W-1:0]     settle_cycles,
  input  logic                    abort,
  input  logic                    adc_valid,
  input  logic [NUM_CH*ADC_W-1:0] adc_data,
  output logic                    busy,
  output logic                    meas_valid,
  input  logic                    meas_ready,
  output logic [NUM_CH*ADC_W-1:0] meas_data,
  output logic [NUM_CH-1:0]       meas_sat,
  output logic [7:0]              meas_seq
);

  localparam int ACC_W = ADC_W + AVG_LOG2;
  localparam int CNT_W = AVG_LOG2 + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'((1 << AVG_LOG2) - 1);
  localparam logic [ADC_W-1:0] FULL = '1;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    ACCUM,
    HOLD
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [SETTLE_W-1:0] settle_cnt;
  logic [CNT_W-1:0]    samp_cnt;
  logic [ACC_W-1:0]    acc [NUM_CH];
  logic [ACC_W-1:0]    sum [NUM_CH];
  logic [NUM_CH-1:0]   sat_acc;
  logic [NUM_CH-1:0]   hit;

  logic load;
  logic take;
  logic done;
  logic hs;

  always_comb begin
    hit = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      sum[c] = acc[c] + ACC_W'(adc_data[c*ADC_W +: ADC_W]);
      hit[c] = (adc_data[c*ADC_W +: ADC_W] == FULL);
    end
  end

  // abort outranks every other event on the same edge
  assign hs   = !abort && (state == HOLD) && meas_ready;
  assign load = !abort && start && ((state == IDLE) || hs);
  assign take = !abort && (state == ACCUM) && adc_valid;
  assign done = take && (samp_cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (start)
            state_nxt = (settle_cycles != '0) ? SETTLE : ACCUM;
        end
        SETTLE: begin
          if (settle_cnt == SETTLE_W'(1)) state_nxt = ACCUM;
        end
        ACCUM: begin
          if (done) state_nxt = HOLD;
        end
        HOLD: begin
          if (meas_ready) begin
            if (start)
              state_nxt = (settle_cycles != '0) ? SETTLE : ACCUM;
            else
              state_nxt = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    busy       = (state != IDLE);
    meas_valid = (state == HOLD);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      settle_cnt <= '0;
      samp_cnt   <= '0;
      sat_acc    <= '0;
      for (int c = 0; c < NUM_CH; c++) acc[c] <= '0;
    end else if (load) begin
      settle_cnt <= settle_cycles;
      samp_cnt   <= '0;
      sat_acc    <= '0;
      for (int c = 0; c < NUM_CH; c++) acc[c] <= '0;
    end else if (!abort && state == SETTLE) begin
      settle_cnt <= settle_cnt - SETTLE_W'(1);
    end else if (take) begin
      samp_cnt <= samp_cnt + CNT_W'(1);
      sat_acc  <= sat_acc | hit;
      for (int c = 0; c < NUM_CH; c++) acc[c] <= sum[c];
    end
  end

  // result registers only change on completion, so they persist outside HOLD
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meas_data <= '0;
      meas_sat  <= '0;
      meas_seq  <= '0;
    end else begin
      if (done) begin
        meas_sat <= sat_acc | hit;
        for (int c = 0; c < NUM_CH; c++)
          meas_data[c*ADC_W +: ADC_W] <= sum[c][ACC_W-1:AVG_LOG2];
      end
      if (hs) meas_seq <= meas_seq + 8'd1;
    end
  end

endmodule

// File: tb/tb_meas_avg_engine.sv
// Directed bench for meas_avg_engine with NUM_CH=2, ADC_W=12, AVG_LOG2=3.
module tb_meas_avg_engine;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  settle_cycles;
  logic        abort;
  logic        adc_valid;
  logic [23:0] adc_data;
  logic        busy;
  logic        meas_valid;
  logic        meas_ready;
  logic [23:0] meas_data;
  logic [1:0]  meas_sat;
  logic [7:0]  meas_seq;

  int vectors;
  int miscompares;

  meas_avg_engine dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .settle_cycles(settle_cycles),
    .abort(abort),
    .adc_valid(adc_valid),
    .adc_data(adc_data),
    .busy(busy),
    .meas_valid(meas_valid),
    .meas_ready(meas_ready),
    .meas_data(meas_data),
    .meas_sat(meas_sat),
    .meas_seq(meas_seq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_meas(input logic [7:0] s);
    start = 1'b1;
    settle_cycles = s;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #22;
    vectors++;
    if ({busy, meas_valid, meas_data, meas_sat, meas_seq} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got busy=%b mv=%b data=%h sat=%b seq=%0d required all 0",
               busy, meas_valid, meas_data, meas_sat, meas_seq);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_constant();
    adc_valid = 1'b1;
    adc_data = {12'h123, 12'h400};
    start_meas(8'd16);
    for (int i = 1; i < 24; i++) begin
      tick();
      vectors++;
      if (meas_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL const_early_valid: edge %0d got %b required 0", i, meas_valid);
      end
    end
    tick();
    vectors++;
    if (meas_valid !== 1'b1 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL const_valid_at_24: got mv=%b busy=%b required 1 1", meas_valid, busy);
    end
    vectors++;
    if (meas_data !== 24'h123400 || meas_sat !== 2'b00) begin
      miscompares++;
      $display("FAIL const_data: got %h sat=%b required 123400 sat=00", meas_data, meas_sat);
    end
    vectors++;
    if (meas_seq !== 8'd0) begin
      miscompares++;
      $display("FAIL const_seq_before: got %0d required 0", meas_seq);
    end
    meas_ready = 1'b1;
    tick();
    meas_ready = 1'b0;
    vectors++;
    if (meas_seq !== 8'd1 || busy !== 1'b0 || meas_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL const_handshake: got seq=%0d busy=%b mv=%b required 1 0 0",
               meas_seq, busy, meas_valid);
    end
  endtask

  task automatic test_truncation();
    adc_valid = 1'b0;
    start_meas(8'd0);
    for (int k = 0; k < 8; k++) begin
      adc_valid = 1'b0;
      adc_data = {12'h010, 12'hFFF};
      tick();
      vectors++;
      if (meas_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL trunc_gap_valid: gap %0d got %b required 0", k, meas_valid);
      end
      adc_valid = 1'b1;
      adc_data = {12'h010, 12'(k)};
      tick();
      vectors++;
      if (meas_valid !== (k == 7)) begin
        miscompares++;
        $display("FAIL trunc_sample_valid: sample %0d got %b required %b", k, meas_valid, k == 7);
      end
    end
    adc_valid = 1'b0;
    vectors++;
    if (meas_data !== 24'h010003 || meas_sat !== 2'b00) begin
      miscompares++;
      $display("FAIL trunc_data: got %h sat=%b required 010003 sat=00", meas_data, meas_sat);
    end
    meas_ready = 1'b1;
    tick();
    meas_ready = 1'b0;
    vectors++;
    if (meas_seq !== 8'd2) begin
      miscompares++;
      $display("FAIL trunc_seq: got %0d required 2", meas_seq);
    end
  endtask

  task automatic test_saturation();
    adc_valid = 1'b1;
    adc_data = {12'h100, 12'h100};
    start_meas(8'd0);
    for (int k = 0; k < 8; k++) begin
      adc_data = {(k == 3) ? 12'hFFF : 12'h100, 12'h100};
      tick();
    end
    vectors++;
    if (meas_valid !== 1'b1 || meas_data !== 24'h2DF100 || meas_sat !== 2'b10) begin
      miscompares++;
      $display("FAIL sat_result: got mv=%b data=%h sat=%b required 1 2df100 10",
               meas_valid, meas_data, meas_sat);
    end
    meas_ready = 1'b1;
    tick();
    meas_ready = 1'b0;
    vectors++;
    if (meas_seq !== 8'd3) begin
      miscompares++;
      $display("FAIL sat_seq: got %0d required 3", meas_seq);
    end
  endtask

  task automatic test_abort();
    adc_valid = 1'b1;
    adc_data = {12'hFFF, 12'hFFF};
    start_meas(8'd0);
    repeat (4) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    vectors++;
    if (busy !== 1'b0 || meas_valid !== 1'b0 || meas_seq !== 8'd3) begin
      miscompares++;
      $display("FAIL abort_idle: got busy=%b mv=%b seq=%0d required 0 0 3",
               busy, meas_valid, meas_seq);
    end
    for (int i = 0; i < 12; i++) begin
      tick();
      vectors++;
      if (meas_valid !== 1'b0 || busy !== 1'b0) begin
        miscompares++;
        $display("FAIL abort_quiet: cycle %0d got mv=%b busy=%b required 0 0", i, meas_valid, busy);
      end
    end
    adc_data = {12'h050, 12'h200};
    start_meas(8'd2);
    for (int i = 1; i < 10; i++) begin
      tick();
      vectors++;
      if (meas_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL abort_restart_early: edge %0d got %b required 0", i, meas_valid);
      end
    end
    tick();
    vectors++;
    if (meas_valid !== 1'b1 || meas_data !== 24'h050200 || meas_sat !== 2'b00) begin
      miscompares++;
      $display("FAIL abort_restart_result: got mv=%b data=%h sat=%b required 1 050200 00",
               meas_valid, meas_data, meas_sat);
    end
    abort = 1'b1;
    meas_ready = 1'b1;
    start = 1'b1;
    tick();
    abort = 1'b0;
    meas_ready = 1'b0;
    start = 1'b0;
    vectors++;
    if (busy !== 1'b0 || meas_valid !== 1'b0 || meas_seq !== 8'd3) begin
      miscompares++;
      $display("FAIL abort_priority: got busy=%b mv=%b seq=%0d required 0 0 3",
               busy, meas_valid, meas_seq);
    end
    vectors++;
    if (meas_data !== 24'h050200) begin
      miscompares++;
      $display("FAIL abort_retain_data: got %h required 050200", meas_data);
    end
  endtask

  task automatic test_back_to_back();
    adc_valid = 1'b1;
    adc_data = {12'h555, 12'h0AA};
    start_meas(8'd0);
    repeat (8) tick();
    vectors++;
    if (meas_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_valid: got %b required 1", meas_valid);
    end
    for (int i = 0; i < 10; i++) begin
      adc_data = {12'(i * 7), 12'(i * 13)};
      start = i[0];
      tick();
      vectors++;
      if (meas_valid !== 1'b1 || busy !== 1'b1 || meas_data !== 24'h5550AA ||
          meas_sat !== 2'b00 || meas_seq !== 8'd3) begin
        miscompares++;
        $display("FAIL bp_stable: cycle %0d got mv=%b data=%h sat=%b seq=%0d required 1 5550aa 00 3",
                 i, meas_valid, meas_data, meas_sat, meas_seq);
      end
    end
    adc_data = {12'h777, 12'h321};
    meas_ready = 1'b1;
    start = 1'b1;
    settle_cycles = 8'd3;
    tick();
    meas_ready = 1'b0;
    start = 1'b0;
    vectors++;
    if (busy !== 1'b1 || meas_valid !== 1'b0 || meas_seq !== 8'd4) begin
      miscompares++;
      $display("FAIL b2b_restart: got busy=%b mv=%b seq=%0d required 1 0 4",
               busy, meas_valid, meas_seq);
    end
    for (int i = 1; i < 11; i++) begin
      tick();
      vectors++;
      if (meas_valid !== 1'b0 || busy !== 1'b1) begin
        miscompares++;
        $display("FAIL b2b_early: edge %0d got mv=%b busy=%b required 0 1", i, meas_valid, busy);
      end
    end
    tick();
    vectors++;
    if (meas_valid !== 1'b1 || meas_data !== 24'h777321) begin
      miscompares++;
      $display("FAIL b2b_result: got mv=%b data=%h required 1 777321", meas_valid, meas_data);
    end
    meas_ready = 1'b1;
    tick();
    meas_ready = 1'b0;
    vectors++;
    if (meas_seq !== 8'd5 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_seq: got seq=%0d busy=%b required 5 0", meas_seq, busy);
    end
  endtask

  task automatic test_reset_mid();
    adc_valid = 1'b1;
    adc_data = {12'hABC, 12'h123};
    start_meas(8'd0);
    repeat (3) tick();
    rst = 1'b1;
    #1;
    vectors++;
    if ({busy, meas_valid, meas_data, meas_sat, meas_seq} !== '0) begin
      miscompares++;
      $display("FAIL mid_reset_outputs: got busy=%b mv=%b data=%h sat=%b seq=%0d required all 0",
               busy, meas_valid, meas_data, meas_sat, meas_seq);
    end
    #2;
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      vectors++;
      if (meas_valid !== 1'b0 || busy !== 1'b0) begin
        miscompares++;
        $display("FAIL mid_reset_quiet: cycle %0d got mv=%b busy=%b required 0 0", i, meas_valid, busy);
      end
    end
    start_meas(8'd0);
    repeat (8) tick();
    vectors++;
    if (meas_valid !== 1'b1 || meas_data !== 24'hABC123) begin
      miscompares++;
      $display("FAIL mid_reset_resume: got mv=%b data=%h required 1 abc123", meas_valid, meas_data);
    end
    meas_ready = 1'b1;
    tick();
    meas_ready = 1'b0;
    vectors++;
    if (meas_seq !== 8'd1) begin
      miscompares++;
      $display("FAIL mid_reset_seq: got %0d required 1", meas_seq);
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst = 1'b1;
    start = 1'b0;
    settle_cycles = 8'd0;
    abort = 1'b0;
    adc_valid = 1'b0;
    adc_data = '0;
    meas_ready = 1'b0;
    test_reset();
    test_constant();
    test_truncation();
    test_saturation();
    test_abort();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/meas_avg_engine.md
MEAS_AVG_ENGINE -- requirements
Module: meas_avg_engine

Interface
REQ-001 SHALL provide parameter NUM_CH, default 2, number of ADC output channels.
REQ-002 SHALL provide parameter ADC_W, default 12, ADC sample width (unsigned codes).
REQ-003 SHALL provide parameter SETTLE_W, default 8, settle-count width.
REQ-004 SHALL provide parameter AVG_LOG2, default 3, log2 of samples averaged per measurement (N = 2^AVG_LOG2).
REQ-005 SHALL use one clock and an asynchronous, active-high reset.
REQ-006 SHALL provide port: clk  input  1  clock.
REQ-007 SHALL provide port: rst  input  1  asynchronous active-high reset.
REQ-008 SHALL provide port: start  input  1  request a measurement.
REQ-009 SHALL provide port: settle_cycles  input  SETTLE_W  settle length S; sampled only when start is accepted.
REQ-010 SHALL provide port: abort  input  1  cancel the measurement in progress.
REQ-011 SHALL provide port: adc_valid  input  1  ADC sample strobe.
REQ-012 SHALL provide port: adc_data  input  NUM_CH*ADC_W  channel c at bits [c*ADC_W +: ADC_W].
REQ-013 SHALL provide port: busy  output  1  state not IDLE.
REQ-014 SHALL provide port: meas_valid  output  1  result available.
REQ-015 SHALL provide port: meas_ready  input  1  consumer accepts the result.
REQ-016 SHALL provide port: meas_data  output  NUM_CH*ADC_W  per-channel averages, packed like adc_data.
REQ-017 SHALL provide port: meas_sat  output  NUM_CH  per-channel saturation flag for the current result.
REQ-018 SHALL provide port: meas_seq  output  8  count of delivered results.

Function
REQ-019 SHALL implement FSM states IDLE, SETTLE, ACCUM, HOLD.
REQ-020 IDLE with start=1: latch S; clear the accumulators, sample counter and saturation flags; go to SETTLE if S>0, otherwise go to ACCUM.
REQ-021 SETTLE: decrement the counter each edge; ignore adc_valid; go to ACCUM at the edge where the counter equals 1, giving exactly S edges in SETTLE.
REQ-022 ACCUM: on each edge with adc_valid=1, add each channel to its own ACC_W = ADC_W+AVG_LOG2 bit accumulator (overflow impossible) and increment the sample count.
REQ-023 ACCUM: set meas_sat[c] if any accepted channel-c sample equals 2^ADC_W-1; the flag is sticky for the measurement.
REQ-024 ACCUM: at the edge accepting the Nth sample, register meas_data[c] = (acc[c] + sample[c]) >> AVG_LOG2 (truncate), enter HOLD, and assert meas_valid.
REQ-025 Latency: with adc_valid held at 1, meas_valid SHALL rise S+N edges after the edge that accepts start.
REQ-026 HOLD: hold meas_valid, meas_data and meas_sat stable until meas_valid&&meas_ready.
REQ-027 On the handshake edge: increment meas_seq (wrap 255->0); go to IDLE, or, if start=1 on the same edge, apply REQ-020 directly (back-to-back, busy stays 1).
REQ-028 start SHALL be ignored in SETTLE and ACCUM, and in HOLD except on the handshake edge.
REQ-029 abort=1 in any state SHALL force IDLE at the next edge: meas_valid to 0, meas_seq unchanged, result discarded.
REQ-030 abort SHALL take priority over start, completion and handshake on the same edge.
REQ-031 meas_data and meas_sat SHALL retain their last values outside HOLD and are valid only while meas_valid=1.
REQ-032 busy SHALL be combinationally (state != IDLE).

Reset
REQ-033 While rst=1: state IDLE; busy, meas_valid, meas_data, meas_sat, meas_seq, accumulators and counters are all 0, asynchronously.
REQ-034 Reset asserted mid-operation SHALL discard the measurement with no meas_valid pulse; operation resumes on the first edge after deassertion.

Verification (NUM_CH=2, ADC_W=12, AVG_LOG2=3)
REQ-035 Constant data: S=16, ch0=0x400, ch1=0x123, adc_valid=1 -> meas_valid rises 24 edges after start; data 0x400/0x123; meas_sat=00; meas_seq 0->1 after handshake.
REQ-036 Truncation with gaps: S=0, ch0 samples 0..7 with adc_valid toggling -> ch0 result 0x003 (28>>3); result only after the 8th valid sample.
REQ-037 Saturation: one ch1 sample = 0xFFF, others 0x100 -> meas_sat=10 (ch1 set); ch1 result 0x2DF.
REQ-038 Abort: abort after 4 ACCUM samples -> IDLE next edge, no meas_valid, meas_seq unchanged; next start with ch0=0x200 -> result 0x200, unaffected by the aborted samples.
REQ-039 Backpressure: meas_ready=0 for 10 cycles -> outputs stable; then ready=1 and start=1 on the same edge -> SETTLE next cycle, busy stays 1, meas_seq increments once.
REQ-040 Reset mid-ACCUM -> all outputs 0 immediately; no result afterwards until a new start.
